// File: rtl/spi_rx_if.sv
// spi_rx_if: SPI pins, CPU pop/clr_err strobes and the status/data word of the SPI receiver.
// The master modport is the environment (SPI master plus CPU); the slave modport is the receiver.
interface spi_rx_if;
    logic        spi_cs_;
    logic        spi_sck;
    logic        spi_sdi;
    logic        spi_dc;
    logic        pop;
    logic        clr_err;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output spi_cs_, spi_sck, spi_sdi, spi_dc, pop, clr_err,
        input  rdata, irq
    );

    modport slave (
        input  spi_cs_, spi_sck, spi_sdi, spi_dc, pop, clr_err,
        output rdata, irq
    );
endinterface

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-3 slave receiver, 8-bit frames tagged with D/C, into an 8-entry FIFO read as one status/data word.
// Latency: pin SCK rise of bit 0 to count update is SYNC_STAGES+1 clk edges; pop takes effect on its own edge.
// Backpressure: none toward SPI; a full FIFO drops the byte and sets sticky ovf. irq exists only with SPI_RX_IRQ_EN.
module spi_rx #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset,
    spi_rx_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    // Pin vector order {dc, sdi, sck, cs_}; reset to the bus idle levels.
    localparam logic [3:0] PIN_IDLE = 4'b0011;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [1:0]                  hist_q, hist_d;
    logic [SYNC_STAGES-1:0]      settle_q, settle_d;
    logic                        armed_q, armed_d;
    state_t                      state_q, state_d;
    logic [2:0]                  bitcnt_q, bitcnt_d;
    logic [7:0]                  shreg_q, shreg_d;
    logic [8:0]                  mem_q [DEPTH];
    logic [8:0]                  mem_d [DEPTH];
    logic [2:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]                  count_q, count_d;
    logic                        ovf_q, ovf_d, ferr_q, ferr_d;

    logic       s_cs, s_sck, s_sdi, s_dc;
    logic       cs_fall, cs_rise, sck_rise;
    logic       push, ferr_set, do_push, do_pop, full, valid;
    logic [7:0] shifted;
    logic [8:0] push_dat, head;

    assign {s_dc, s_sdi, s_sck, s_cs} = sync_q[SYNC_STAGES-1];
    // A frame may only start once a genuine high CS_ has been seen after reset.
    assign cs_fall  = armed_q & hist_q[0] & ~s_cs;
    assign cs_rise  = ~hist_q[0] & s_cs;
    assign sck_rise = ~hist_q[1] & s_sck;
    assign shifted  = {shreg_q[6:0], s_sdi};
    assign push_dat = {s_dc, shifted};

    always_comb begin
        sync_d[0] = {bus.spi_dc, bus.spi_sdi, bus.spi_sck, bus.spi_cs_};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        hist_d      = sync_q[SYNC_STAGES-1][1:0];
        settle_d    = settle_q << 1;
        settle_d[0] = 1'b1;
        armed_d     = armed_q | (settle_q[SYNC_STAGES-1] & s_cs);
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    shreg_d  = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    ferr_set = (bitcnt_q != 3'd0);
                    bitcnt_d = '0;
                end else if (sck_rise) begin
                    shreg_d = shifted;
                    if (bitcnt_q == 3'd7) begin
                        push     = 1'b1;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full     = (count_q == 4'(DEPTH));
        do_pop   = bus.pop & (count_q != 4'd0);
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d = wr_ptr_q + {2'b0, do_push};
        rd_ptr_d = rd_ptr_q + {2'b0, do_pop};
        count_d  = count_q + {3'b0, do_push} - {3'b0, do_pop};
        ovf_d    = (ovf_q & ~bus.clr_err) | (push & ~do_push);
        ferr_d   = (ferr_q & ~bus.clr_err) | ferr_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{PIN_IDLE}};
            hist_q   <= PIN_IDLE[1:0];
            settle_q <= '0;
            armed_q  <= 1'b0;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            settle_q <= settle_d;
            armed_q  <= armed_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    assign valid     = (count_q != 4'd0);
    assign head      = valid ? mem_q[rd_ptr_q] : 9'd0;
    assign bus.rdata = {16'h0, valid, ovf_q, ferr_q, count_q, head};

`ifdef SPI_RX_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = valid;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed plus randomized SPI frames against a queue model of the receive FIFO and its flags.
`timescale 1ns/1ps
module tb_spi_rx;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    spi_rx_if b ();
    spi_rx dut (.clk(clk), .reset(reset), .bus(b));

    always #8 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [8:0] mq [$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;

    function automatic logic [31:0] exp_rdata();
        logic [8:0] hd;
        hd = (mq.size() != 0) ? mq[0] : 9'd0;
        return {16'h0, mq.size() != 0, m_ovf, m_ferr, 4'(mq.size()), hd};
    endfunction

    function automatic logic exp_irq(input logic v);
`ifdef SPI_RX_IRQ_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic bv, input logic dcv);
        b.spi_sck = 1'b0; b.spi_sdi = bv; b.spi_dc = dcv;
        clocks(5);
        b.spi_sck = 1'b1;
        clocks(5);
    endtask

    task automatic cs_low();
        b.spi_cs_ = 1'b0;
        clocks(5);
    endtask

    task automatic cs_high();
        clocks(5);
        b.spi_cs_ = 1'b1;
        clocks(6);
    endtask

    // Full byte; the last rising edge is timed so the push edge can be checked exactly.
    task automatic send_byte(input logic [7:0] d, input logic dcv, input logic pop_with);
        logic [31:0] pre_rd;
        logic        pre_irq;
        for (int i = 7; i >= 1; i--) spi_bit(d[i], dcv);
        b.spi_sck = 1'b0; b.spi_sdi = d[0]; b.spi_dc = dcv;
        clocks(5);
        pre_rd  = exp_rdata();
        pre_irq = exp_irq(mq.size() != 0);
        b.spi_sck = 1'b1;
        clocks(2);
        check("before_push_edge", b.rdata, pre_rd);
        if (pop_with) b.pop = 1'b1;
        clocks(1);
        b.pop = 1'b0;
        if (pop_with && mq.size() != 0) void'(mq.pop_front());
        if (mq.size() < 8) mq.push_back({dcv, d});
        else m_ovf = 1'b1;
        check("push_edge", b.rdata, exp_rdata());
        check("irq_at_push", {31'b0, b.irq}, {31'b0, pre_irq});
        clocks(1);
        check("irq_after_push", {31'b0, b.irq}, {31'b0, exp_irq(mq.size() != 0)});
        clocks(3);
    endtask

    task automatic do_pop();
        logic was_valid;
        was_valid = (mq.size() != 0);
        b.pop = 1'b1;
        clocks(1);
        b.pop = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        check("pop_head", b.rdata, exp_rdata());
        check("irq_at_pop", {31'b0, b.irq}, {31'b0, exp_irq(was_valid)});
        clocks(1);
        check("irq_after_pop", {31'b0, b.irq}, {31'b0, exp_irq(mq.size() != 0)});
    endtask

    task automatic do_clr();
        b.clr_err = 1'b1;
        clocks(1);
        b.clr_err = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0;
        check("clr_err", b.rdata, exp_rdata());
    endtask

    initial begin
        logic [7:0] rb;
        int         nb, np;
        b.spi_cs_ = 1'b1; b.spi_sck = 1'b1; b.spi_sdi = 1'b0; b.spi_dc = 1'b0;
        b.pop = 1'b0; b.clr_err = 1'b0;
        clocks(3);
        check("reset_rdata", b.rdata, 32'h0);
        check("reset_irq", {31'b0, b.irq}, 32'h0);
        reset = 1'b0;
        clocks(4);
        do_pop();

        cs_low(); send_byte(8'hA5, 1'b1, 1'b0); cs_high();
        check("one_byte", b.rdata, 32'h0000_83A5);
        do_pop();
        check("one_byte_empty", b.rdata, 32'h0);

        cs_low();
        for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b0, 1'b0);
        cs_high();
        check("burst_count", b.rdata, 32'h0000_8601);
        for (int i = 0; i < 3; i++) do_pop();

        cs_low();
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
        cs_high();
        check("overflow", b.rdata, 32'h0000_D010);
        do_clr();
        cs_low(); send_byte(8'h55, 1'b1, 1'b1); cs_high();
        check("full_push_pop", b.rdata, 32'h0000_9011);
        for (int i = 0; i < 8; i++) do_pop();

        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0);
        cs_high();
        m_ferr = 1'b1;
        check("framing", b.rdata, exp_rdata());
        cs_low(); send_byte(8'h3C, 1'b0, 1'b0); cs_high();
        check("after_framing", b.rdata, exp_rdata());
        do_pop();
        do_clr();

        cs_low();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1);
        reset = 1'b1;
        clocks(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b1);
        cs_high();
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        check("reset_midframe", b.rdata, 32'h0);
        check("reset_midframe_irq", {31'b0, b.irq}, 32'h0);
        cs_low(); send_byte(8'hC3, 1'b1, 1'b0); cs_high();
        check("after_reset_frame", b.rdata, exp_rdata());

        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 4);
            cs_low();
            for (int k = 0; k < nb; k++) begin
                rb = 8'($urandom);
                send_byte(rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
            end
            cs_high();
            check("rand_frame", b.rdata, exp_rdata());
            np = $urandom_range(0, mq.size());
            for (int k = 0; k < np; k++) do_pop();
            if ($urandom_range(0, 2) == 0) do_clr();
        end
        while (mq.size() != 0) do_pop();
        check("final_empty", b.rdata, {16'h0, 1'b0, m_ovf, m_ferr, 13'h0});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
# spi_rx

SPI mode-3 slave receiver for the 62.5 MHz CPU domain. It captures 8-bit frames, each tagged with a D/C bit, from an external SPI master whose framing matches the system's 8-bit SPI output driver: SCK idles high, data changes on the falling edge, data is sampled on the rising edge, MSB first, and CS_ is active-low. Received bytes are buffered in a small FIFO and exposed to the MIPS core as one memory-mapped status/data word with a pop strobe, plus an optional interrupt.

## Interface
Parameters:
- DEPTH, 8, FIFO entries. Fixed at 8; count field is 4 bits.
- SYNC_STAGES, 2, synchronizer flops per async input, before the edge-detect flop.

Ports:
- clk  in  1  system clock (62.5 MHz).
- reset  in  1  synchronous, active-high reset.
- spi_cs_  in  1  async; active-low frame select.
- spi_sck  in  1  async; serial clock, idles high.
- spi_sdi  in  1  async; serial data.
- spi_dc  in  1  async; data/command tag, sampled with bit 0.
- pop  in  1  one-cycle strobe; CPU read of the data register consumes the FIFO head.
- clr_err  in  1  one-cycle strobe; clears `ovf` and `ferr`.
- rdata  out  32  bit 15 valid (FIFO not empty), bit 14 ovf, bit 13 ferr, bits 12:9 count (0..8), bit 8 head dc, bits 7:0 head byte, bits 31:16 zero.
- irq  out  1  receive interrupt (see Configuration).

## Operation
- Synchronizers: spi_cs_, spi_sck, spi_sdi and spi_dc each pass through SYNC_STAGES flops, then one history flop. Edge detects are taken on the synchronized values. Synchronized SCK and SDI have equal delay.
- FSM states:
  - IDLE → SHIFT on a synchronized CS_ falling edge; clear bitcnt and shreg.
  - SHIFT: on each synchronized SCK rising edge, shreg <= {shreg[6:0], sdi}; bitcnt++.
  - On the 8th bit, push {dc, byte} using the just-shifted value and dc sampled on that same edge, then set bitcnt = 0 and stay in SHIFT. Several bytes per CS_ low are allowed.
  - SHIFT → IDLE on a synchronized CS_ rising edge. If bitcnt != 0, set `ferr` (sticky) and discard the partial byte.
- SCK edges seen in IDLE are ignored.
- FIFO: flop array, wr/rd pointers mod 8, 4-bit count.
  - Push when full: drop the byte and set `ovf` (sticky).
  - Pop when empty: ignored; no state change.
  - Push and pop in the same cycle: both take effect and count is unchanged. If the FIFO is full, the new byte is accepted and `ovf` is not set.
- rdata is combinational from the head entry and the flags. When empty, bits 8:0 read 0.
- clr_err clears both sticky flags. If an overflow or framing error occurs in the same cycle as clr_err, the flag is set (set wins).

## Timing
- Reset values:
  - FSM IDLE; bitcnt 0; shreg 0; pointers and count 0.
  - ovf 0, ferr 0; rdata 0; irq 0.
  - Synchronizers reset to idle levels: cs_ 1, sck 1, sdi 0, dc 0.
- Reset mid-frame aborts the frame silently. If CS_ is still low when reset is released, no frame starts until a fresh CS_ falling edge.
- Latency: valid/count update exactly SYNC_STAGES+1 clk edges after the 8th SCK rising edge at the pin, i.e. 3 edges by default.
- Pop: count decrements and the next head is visible in rdata on the edge where pop is high.
- SCK high and low phases must each be ≥ 4 clk periods, so SCK ≤ 7.8 MHz. The system's 1.25 MHz SPI rate is compliant.
- CS_ setup before the first SCK falling edge must be ≥ 4 clk periods. CS_ hold after the last SCK rising edge must be ≥ 4 clk periods.

## Configuration
- SPI_RX_IRQ_EN:
  - Defined: irq is registered and equals valid (FIFO not empty), delayed one clk after the count update. It drops on the edge after the pop that empties the FIFO.
  - Undefined: irq is tied to 0 and no irq flop exists. The CPU polls rdata[15].

## Test plan
- One byte: CS_ low, send 0xA5 with dc=1, CS_ high → rdata = 0x0000_83A5 (valid, count 1, dc 1); after one pop, rdata = 0.
- Burst: 3 bytes 0x01, 0x02, 0x03 (dc=0) in one CS_ low → count 3; successive pops return 0x01, 0x02, 0x03 in order; no ferr.
- Overflow: 9 bytes 0x10..0x18 with no pops → count 8, ovf = 1, 0x18 dropped. Pop and push in the same cycle while full → count stays 8, ovf not re-set. clr_err → ovf = 0.
- Framing: CS_ high after 5 SCK rising edges → ferr = 1, count unchanged; the next full byte is received correctly.
- Reset mid-frame: reset after 4 bits with CS_ held low, then 4 more bits and CS_ high → no push, ferr = 0, all outputs 0.
- IRQ (macro defined): irq rises 4 clk after the 8th SCK edge and falls the edge after the emptying pop. With the macro undefined, irq stays 0 throughout.
